// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the CPU load/store stage (master) and data_memory_ctrl (slave).
// Also carries the clear request and the busy flag of the clear sequencer.
interface data_memory_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                    clear_req;
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_byte_en;
   logic                    rsp_valid;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    addr_err;
   logic                    busy;

   modport master (
      output clear_req, req_valid, req_write, req_addr, req_wdata, req_byte_en,
      input  req_ready, rsp_valid, rsp_rdata, addr_err, busy
   );

   modport slave (
      input  clear_req, req_valid, req_write, req_addr, req_wdata, req_byte_en,
      output req_ready, rsp_valid, rsp_rdata, addr_err, busy
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-port synchronous data memory with byte-lane stores, address range checking
// and a clear sequencer that zeroes one word per cycle after reset or on clear_req.
module data_memory_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   data_memory_ctrl_if.slave bus
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AW1   = ADDR_WIDTH + 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [AW1-1:0]   DEPTH_LIM = AW1'(DEPTH);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  pend_load_q, pend_load_d;
   logic                  pend_err_q, pend_err_d;
   logic                  pend_hit_q, pend_hit_d;
   logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  addr_err_q, addr_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic                  req_ready_s;
   logic                  accept_s;
   logic                  in_range_s;
   logic                  store_s;
   logic                  clear_we_s;
   logic [IDX_W-1:0]      idx_s;

   // clear_req must drop ready in the same cycle so a colliding request is held, not lost
   assign req_ready_s = (state_q == ST_READY) && !bus.clear_req;
   assign accept_s    = bus.req_valid && req_ready_s;
   assign in_range_s  = ({1'b0, bus.req_addr} < DEPTH_LIM);
   assign idx_s       = bus.req_addr[IDX_W-1:0];
   assign store_s     = accept_s && bus.req_write && in_range_s;
   assign clear_we_s  = (state_q == ST_CLEAR);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (ptr_q == LAST_IDX) begin
               state_d = ST_READY;
               ptr_d   = '0;
            end else begin
               state_d = ST_CLEAR;
               ptr_d   = ptr_q + IDX_ONE;
            end
         end
         ST_READY: begin
            if (bus.clear_req) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end else begin
               state_d = ST_READY;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   // Accepted requests sit one stage in pend_*; the array is read on the following edge.
   always_comb begin
      pend_load_d = accept_s && !bus.req_write;
      pend_err_d  = accept_s && !in_range_s;
      pend_hit_d  = in_range_s;
      pend_idx_d  = idx_s;
      rsp_valid_d = pend_load_q;
      addr_err_d  = pend_err_q;
      if (pend_load_q && pend_hit_q) begin
         rsp_rdata_d = mem_q[pend_idx_q];
      end else if (pend_load_q) begin
         rsp_rdata_d = '0;
      end else begin
         rsp_rdata_d = rsp_rdata_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_CLEAR;
         ptr_q       <= '0;
         pend_load_q <= 1'b0;
         pend_err_q  <= 1'b0;
         pend_hit_q  <= 1'b0;
         pend_idx_q  <= '0;
         rsp_valid_q <= 1'b0;
         addr_err_q  <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         pend_load_q <= pend_load_d;
         pend_err_q  <= pend_err_d;
         pend_hit_q  <= pend_hit_d;
         pend_idx_q  <= pend_idx_d;
         rsp_valid_q <= rsp_valid_d;
         addr_err_q  <= addr_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // The array has no reset of its own; zeroing is the sweep's job.
   always_ff @(posedge clk_i) begin
      if (!rst_i && clear_we_s) begin
         mem_q[ptr_q] <= '0;
      end else if (!rst_i && store_s) begin
         for (int lane = 0; lane < LANES; lane++) begin
            if (bus.req_byte_en[lane]) begin
               mem_q[idx_s][8*lane +: 8] <= bus.req_wdata[8*lane +: 8];
            end
         end
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.busy      = (state_q == ST_CLEAR);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: an 8-bit/256-word instance and a 32-bit/200-word instance,
// each scenario in its own task with inline comparisons against hand-computed values.
module tb_data_memory_ctrl;
   logic clk = 1'b0;
   logic rst8;
   logic rst32;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   data_memory_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) if8 ();
   data_memory_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) if32 ();

   data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256)) u_dut8 (
      .clk_i (clk),
      .rst_i (rst8),
      .bus   (if8)
   );

   data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200)) u_dut32 (
      .clk_i (clk),
      .rst_i (rst32),
      .bus   (if32)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv8(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
      if8.req_valid   = v;
      if8.req_write   = w;
      if8.req_addr    = a;
      if8.req_wdata   = d;
      if8.req_byte_en = 1'b1;
   endtask

   task automatic drv32(input logic v, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      if32.req_valid   = v;
      if32.req_write   = w;
      if32.req_addr    = a;
      if32.req_wdata   = d;
      if32.req_byte_en = be;
   endtask

   task automatic test_reset();
      int c8;
      int c32;
      rst8 = 1'b1;
      rst32 = 1'b1;
      step();
      rst8 = 1'b0;
      rst32 = 1'b0;
      n_vec++; if (if8.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", if8.busy); end
      n_vec++; if (if8.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", if8.req_ready); end
      n_vec++; if (if8.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", if8.rsp_valid); end
      n_vec++; if (if8.rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h expected 00", if8.rsp_rdata); end
      n_vec++; if (if8.addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err: got %b expected 0", if8.addr_err); end
      c8 = 0;
      c32 = 0;
      for (int i = 0; i < 400; i++) begin
         if (if8.busy === 1'b1) c8++;
         if (if32.busy === 1'b1) c32++;
         n_vec++; if (if8.busy === 1'b1 && if8.req_ready !== 1'b0) begin n_err++; $display("FAIL sweep_ready: got %b expected 0 at cycle %0d", if8.req_ready, i); end
         step();
      end
      n_vec++; if (c8 !== 256) begin n_err++; $display("FAIL sweep_len8: got %0d cycles expected 256", c8); end
      n_vec++; if (c32 !== 200) begin n_err++; $display("FAIL sweep_len32: got %0d cycles expected 200", c32); end
      n_vec++; if (if8.req_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_sweep: got %b expected 1", if8.req_ready); end
      for (int a = 0; a < 256; a++) begin
         drv8(1'b1, 1'b0, 8'(a), 8'h00);
         step();
         drv8(1'b0, 1'b0, 8'h00, 8'h00);
         step();
         n_vec++;
         if (if8.rsp_valid !== 1'b1 || if8.rsp_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL cleared_word[%0d]: got valid=%b data=%h expected valid=1 data=00", a, if8.rsp_valid, if8.rsp_rdata);
         end
      end
   endtask

   task automatic test_store_load();
      drv8(1'b1, 1'b1, 8'h10, 8'hA5);
      step();
      drv8(1'b1, 1'b0, 8'h10, 8'h00);
      step();
      n_vec++; if (if8.rsp_valid !== 1'b0) begin n_err++; $display("FAIL store_no_rsp: got %b expected 0", if8.rsp_valid); end
      n_vec++; if (if8.addr_err !== 1'b0) begin n_err++; $display("FAIL store_no_err: got %b expected 0", if8.addr_err); end
      drv8(1'b0, 1'b0, 8'h00, 8'h00);
      step();
      n_vec++; if (if8.rsp_valid !== 1'b1) begin n_err++; $display("FAIL raw_valid: got %b expected 1", if8.rsp_valid); end
      n_vec++; if (if8.rsp_rdata !== 8'hA5) begin n_err++; $display("FAIL raw_data: got %h expected a5", if8.rsp_rdata); end
      step();
      n_vec++; if (if8.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_pulse: got %b expected 0", if8.rsp_valid); end
      n_vec++; if (if8.rsp_rdata !== 8'hA5) begin n_err++; $display("FAIL rdata_hold: got %h expected a5", if8.rsp_rdata); end
   endtask

   task automatic test_byte_lanes();
      drv32(1'b1, 1'b1, 8'h05, 32'h11223344, 4'b1111);
      step();
      drv32(1'b1, 1'b1, 8'h05, 32'hAABBCCDD, 4'b0101);
      step();
      drv32(1'b1, 1'b0, 8'h05, 32'h0, 4'b0000);
      step();
      drv32(1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
      step();
      n_vec++; if (if32.rsp_valid !== 1'b1 || if32.rsp_rdata !== 32'h11BB33DD) begin n_err++; $display("FAIL lanes_0101: got valid=%b data=%h expected 1/11bb33dd", if32.rsp_valid, if32.rsp_rdata); end
      drv32(1'b1, 1'b1, 8'h05, 32'hFFFFFFFF, 4'b0000);
      step();
      drv32(1'b1, 1'b0, 8'h05, 32'h0, 4'b0000);
      step();
      drv32(1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
      step();
      n_vec++; if (if32.rsp_rdata !== 32'h11BB33DD) begin n_err++; $display("FAIL lanes_none: got %h expected 11bb33dd", if32.rsp_rdata); end
      drv32(1'b1, 1'b1, 8'h05, 32'h77665544, 4'b1000);
      step();
      drv32(1'b1, 1'b0, 8'h05, 32'h0, 4'b0000);
      step();
      drv32(1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
      step();
      n_vec++; if (if32.rsp_rdata !== 32'h77BB33DD) begin n_err++; $display("FAIL lanes_1000: got %h expected 77bb33dd", if32.rsp_rdata); end
   endtask

   task automatic test_range();
      drv32(1'b1, 1'b1, 8'd250, 32'h0000005A, 4'b1111);
      step();
      n_vec++; if (if32.req_ready !== 1'b1) begin n_err++; $display("FAIL oor_ready: got %b expected 1", if32.req_ready); end
      drv32(1'b1, 1'b0, 8'd250, 32'h0, 4'b0000);
      step();
      n_vec++; if (if32.addr_err !== 1'b1 || if32.rsp_valid !== 1'b0) begin n_err++; $display("FAIL oor_store: got err=%b valid=%b expected 1/0", if32.addr_err, if32.rsp_valid); end
      drv32(1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
      step();
      n_vec++; if (if32.addr_err !== 1'b1 || if32.rsp_valid !== 1'b1 || if32.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL oor_load: got err=%b valid=%b data=%h expected 1/1/0", if32.addr_err, if32.rsp_valid, if32.rsp_rdata); end
      step();
      n_vec++; if (if32.addr_err !== 1'b0) begin n_err++; $display("FAIL oor_pulse: got %b expected 0", if32.addr_err); end
      drv32(1'b1, 1'b1, 8'd199, 32'hCAFEBABE, 4'b1111);
      step();
      drv32(1'b1, 1'b0, 8'd199, 32'h0, 4'b0000);
      step();
      drv32(1'b1, 1'b0, 8'd200, 32'h0, 4'b0000);
      step();
      n_vec++; if (if32.addr_err !== 1'b0 || if32.rsp_rdata !== 32'hCAFEBABE) begin n_err++; $display("FAIL last_word: got err=%b data=%h expected 0/cafebabe", if32.addr_err, if32.rsp_rdata); end
      drv32(1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
      step();
      n_vec++; if (if32.addr_err !== 1'b1 || if32.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL first_oor: got err=%b data=%h expected 1/0", if32.addr_err, if32.rsp_rdata); end
   endtask

   task automatic test_clear_collision();
      int   c;
      logic early;
      if8.clear_req = 1'b1;
      drv8(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      n_vec++; if (if8.req_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready_drop: got %b expected 0", if8.req_ready); end
      step();
      if8.clear_req = 1'b0;
      c = 0;
      early = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (if8.busy !== 1'b1) break;
         c++;
         step();
         if (if8.rsp_valid === 1'b1) early = 1'b1;
      end
      n_vec++; if (c !== 256) begin n_err++; $display("FAIL clear_len: got %0d cycles expected 256", c); end
      n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL held_during_clear: got %b expected 0", early); end
      step();
      drv8(1'b0, 1'b0, 8'h00, 8'h00);
      n_vec++; if (if8.rsp_valid !== 1'b0) begin n_err++; $display("FAIL held_accept_edge: got %b expected 0", if8.rsp_valid); end
      step();
      n_vec++; if (if8.rsp_valid !== 1'b1 || if8.rsp_rdata !== 8'h00) begin n_err++; $display("FAIL held_load: got valid=%b data=%h expected 1/00", if8.rsp_valid, if8.rsp_rdata); end
   endtask

   task automatic test_rst_restart();
      int c;
      drv8(1'b1, 1'b1, 8'h11, 8'h3C);
      step();
      drv8(1'b1, 1'b0, 8'h11, 8'h00);
      step();
      drv8(1'b0, 1'b0, 8'h00, 8'h00);
      rst8 = 1'b1;
      step();
      rst8 = 1'b0;
      n_vec++; if (if8.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_suppress: got %b expected 0", if8.rsp_valid); end
      n_vec++; if (if8.busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b expected 1", if8.busy); end
      for (int i = 0; i < 100; i++) step();
      n_vec++; if (if8.busy !== 1'b1) begin n_err++; $display("FAIL mid_sweep_busy: got %b expected 1", if8.busy); end
      rst8 = 1'b1;
      step();
      rst8 = 1'b0;
      c = 0;
      for (int i = 0; i < 600; i++) begin
         if (if8.busy !== 1'b1) break;
         c++;
         step();
      end
      n_vec++; if (c !== 256) begin n_err++; $display("FAIL restart_len: got %0d cycles expected 256", c); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a_tab [4];
      logic [7:0] d_tab [4];
      a_tab = '{8'h20, 8'h21, 8'h22, 8'h23};
      d_tab = '{8'h3C, 8'hC3, 8'h5A, 8'h96};
      for (int i = 0; i < 4; i++) begin
         drv8(1'b1, 1'b1, a_tab[i], d_tab[i]);
         step();
      end
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drv8(1'b1, 1'b0, a_tab[i], 8'h00);
         else drv8(1'b0, 1'b0, 8'h00, 8'h00);
         step();
         if (i >= 1 && i <= 4) begin
            n_vec++;
            if (if8.rsp_valid !== 1'b1 || if8.rsp_rdata !== d_tab[i-1]) begin
               n_err++;
               $display("FAIL b2b_rsp[%0d]: got valid=%b data=%h expected 1/%h", i - 1, if8.rsp_valid, if8.rsp_rdata, d_tab[i-1]);
            end
         end else begin
            n_vec++;
            if (if8.rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle[%0d]: got %b expected 0", i, if8.rsp_valid); end
         end
      end
   endtask

   initial begin
      rst8 = 1'b1;
      rst32 = 1'b1;
      if8.clear_req = 1'b0;
      if32.clear_req = 1'b0;
      drv8(1'b0, 1'b0, 8'h00, 8'h00);
      drv32(1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
      test_reset();
      test_store_load();
      test_byte_lanes();
      test_range();
      test_clear_collision();
      test_rst_restart();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
